// File: rtl/expu_pkg.sv
// Shared EXPU control package: counter width and counter type.
// Imported by expu_row_ctrl.
package expu_pkg;

  localparam int unsigned CTRL_CNT_WIDTH = 16;

  typedef logic [CTRL_CNT_WIDTH-1:0] expu_ctrl_cnt_t;

endpackage

// File: rtl/expu_ctrl_slot.sv
// One elastic stage of the row controller: a valid/tag pair with its
// advance and load-enable logic.
// Ports: clk, kill (sync clear), v_prev/t_prev in, adv_next in,
//        v/t state out, adv out, en (load enable for this register).
module expu_ctrl_slot (
  input  logic clk,
  input  logic kill,
  input  logic v_prev,
  input  logic t_prev,
  input  logic adv_next,
  output logic v,
  output logic t,
  output logic adv,
  output logic en
);

  // A stage may take new content if empty or if its content moves on.
  assign adv = ~v | adv_next;

  // Only real elements are loaded into the datapath register.
  assign en = adv & v_prev & ~kill;

  always_ff @(posedge clk) begin
    if (kill) begin
      v <= 1'b0;
      t <= 1'b0;
    end else if (adv) begin
      v <= v_prev;
      t <= t_prev;
    end
  end

endmodule

// File: rtl/expu_row_ctrl.sv
// Valid/ready controller driving expu_row enable/clear as an elastic
// pipeline of NUM_REGS stages, with a last-of-row tag and counters.
// Ports: clk_i, rst_i (sync, active-high), flush_i, valid_i/ready_o/last_i
//   upstream, valid_o/ready_i/last_o downstream, enable_o/clear_o to row,
//   busy_o, elem_cnt_o, row_cnt_o, stall_cnt_o.
// Macro EXPU_ROW_CTRL_PERF_EN enables the saturating stall counter.
module expu_row_ctrl
  import expu_pkg::*;
#(
  parameter int unsigned NUM_REGS  = 2,
  parameter int unsigned CNT_WIDTH = CTRL_CNT_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic                 last_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 last_o,
  output logic [((NUM_REGS > 0) ? NUM_REGS : 1)-1:0] enable_o,
  output logic                 clear_o,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] elem_cnt_o,
  output logic [CNT_WIDTH-1:0] row_cnt_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o
);

  logic kill;
  logic in_hs;
  logic out_hs;

  assign kill    = rst_i | flush_i;
  assign clear_o = kill;

  generate
    if (NUM_REGS == 0) begin : g_pass
      assign valid_o  = valid_i;
      assign last_o   = last_i;
      assign ready_o  = ready_i & ~kill;
      assign enable_o = '0;
      assign busy_o   = 1'b0;
    end else begin : g_pipe
      logic [NUM_REGS:0]     v;
      logic [NUM_REGS:0]     t;
      logic [NUM_REGS+1:1]   adv;
      logic [NUM_REGS-1:0]   en;

      // Stage 0 is the upstream port; the stage past N is the sink.
      assign v[0]            = valid_i;
      assign t[0]            = last_i;
      assign adv[NUM_REGS+1] = ready_i;

      for (genvar k = 1; k <= NUM_REGS; k++) begin : g_slot
        expu_ctrl_slot u_slot (
          .clk      (clk_i),
          .kill     (kill),
          .v_prev   (v[k-1]),
          .t_prev   (t[k-1]),
          .adv_next (adv[k+1]),
          .v        (v[k]),
          .t        (t[k]),
          .adv      (adv[k]),
          .en       (en[k-1])
        );
      end

      assign ready_o  = adv[1] & ~kill;
      assign valid_o  = v[NUM_REGS];
      assign last_o   = t[NUM_REGS];
      assign enable_o = en;
      assign busy_o   = |v[NUM_REGS:1];
    end
  endgenerate

  assign in_hs  = valid_i & ready_o;
  assign out_hs = valid_o & ready_i;

  always_ff @(posedge clk_i) begin
    if (kill) begin
      elem_cnt_o <= '0;
    end else if (in_hs) begin
      elem_cnt_o <= last_i ? '0 : elem_cnt_o + 1'b1;
    end
  end

  // A flush still counts a row completing at the output that cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      row_cnt_o <= '0;
    end else if (out_hs & last_o) begin
      row_cnt_o <= row_cnt_o + 1'b1;
    end
  end

`ifdef EXPU_ROW_CTRL_PERF_EN
  logic [CNT_WIDTH-1:0] stall_q;

  always_ff @(posedge clk_i) begin
    if (kill) begin
      stall_q <= '0;
    end else if (valid_o & ~ready_i & ~&stall_q) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_expu_row_ctrl.sv
// Self-checking bench for expu_row_ctrl (NUM_REGS=2, CNT_WIDTH=16).
// Reference model: queue of in-flight elements with pipeline positions.
module tb_expu_row_ctrl;

  localparam int N = 2;

  typedef struct {
    int pos;
    bit tag;
  } el_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic        last_i = 1'b0;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic        last_o;
  logic [N-1:0] enable_o;
  logic        clear_o;
  logic        busy_o;
  logic [15:0] elem_cnt_o;
  logic [15:0] row_cnt_o;
  logic [15:0] stall_cnt_o;

  int checks = 0;
  int failures = 0;

  el_t         q[$];
  logic [15:0] m_elem = '0;
  logic [15:0] m_row = '0;
  logic [15:0] m_stall = '0;

  always #5 clk = ~clk;

  expu_row_ctrl #(
    .NUM_REGS  (N),
    .CNT_WIDTH (16)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .last_i      (last_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .last_o      (last_o),
    .enable_o    (enable_o),
    .clear_o     (clear_o),
    .busy_o      (busy_o),
    .elem_cnt_o  (elem_cnt_o),
    .row_cnt_o   (row_cnt_o),
    .stall_cnt_o (stall_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive, compare against the model at negedge, update model.
  task automatic cycle(input bit rs, input bit vin, input bit lin,
                       input bit rdy, input bit fl);
    el_t        nq[$];
    int         cap;
    int         np;
    bit         vexp;
    bit         rexp;
    bit         acc;
    logic [N-1:0] en;
    logic [15:0] stall_exp;
    rst_i   = rs;
    valid_i = vin;
    last_i  = lin;
    ready_i = rdy;
    flush_i = fl;
    @(negedge clk);
    vexp = (q.size() > 0) && (q[0].pos == N);
    // Each element moves one slot unless blocked by the one ahead.
    cap = rdy ? N + 1 : N;
    en  = '0;
    foreach (q[i]) begin
      np = (q[i].pos + 1 < cap) ? q[i].pos + 1 : cap;
      if (np > q[i].pos && np <= N) en[np-1] = 1'b1;
      if (np <= N) nq.push_back('{np, q[i].tag});
      cap = np - 1;
    end
    rexp = !rs && !fl && (cap >= 1);
    acc  = vin && rexp;
    if (acc) begin
      en[0] = 1'b1;
      nq.push_back('{1, lin});
    end
    if (rs || fl) en = '0;
`ifdef EXPU_ROW_CTRL_PERF_EN
    stall_exp = m_stall;
`else
    stall_exp = '0;
`endif
    chk("ready", 32'(ready_o), 32'(rexp));
    chk("valid", 32'(valid_o), 32'(vexp));
    if (vexp) chk("last", 32'(last_o), 32'(q[0].tag));
    chk("enable", 32'(enable_o), 32'(en));
    chk("clear", 32'(clear_o), 32'(rs | fl));
    chk("busy", 32'(busy_o), 32'(q.size() > 0));
    chk("elem_cnt", 32'(elem_cnt_o), 32'(m_elem));
    chk("row_cnt", 32'(row_cnt_o), 32'(m_row));
    chk("stall_cnt", 32'(stall_cnt_o), 32'(stall_exp));
    if (rs) begin
      q.delete();
      m_elem  = '0;
      m_row   = '0;
      m_stall = '0;
    end else begin
      if (vexp && rdy && q[0].tag) m_row = m_row + 16'd1;
      if (fl) begin
        q.delete();
        m_elem  = '0;
        m_stall = '0;
      end else begin
        if (vexp && !rdy && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
        if (acc) m_elem = lin ? 16'd0 : m_elem + 16'd1;
        q = nq;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 1, 0);
  endtask

  initial begin
    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_clear", 32'(clear_o), 32'd1);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_enable", 32'(enable_o), 32'd0);
    chk("rst_elem", 32'(elem_cnt_o), 32'd0);
    chk("rst_row", 32'(row_cnt_o), 32'd0);
    chk("rst_stall", 32'(stall_cnt_o), 32'd0);
    rst_i = 1'b0;
    #1;
    chk("rel_ready", 32'(ready_o), 32'd1);
    chk("rel_clear", 32'(clear_o), 32'd0);
    @(posedge clk);
    #1;

    // Streaming: one row of 8 back-to-back elements.
    for (int i = 0; i < 8; i++) cycle(0, 1, i == 7, 1, 0);
    idle(3);
    chk("stream_row", 32'(row_cnt_o), 32'd1);
    chk("stream_elem", 32'(elem_cnt_o), 32'd0);

    // Back-pressure: two accepts, then ready_i low for 5 cycles.
    cycle(1, 0, 0, 1, 0);
    cycle(0, 1, 0, 1, 0);
    cycle(0, 1, 0, 1, 0);
    for (int i = 0; i < 5; i++) cycle(0, 1, i == 4, 0, 0);
`ifdef EXPU_ROW_CTRL_PERF_EN
    chk("bp_stall", 32'(stall_cnt_o), 32'd5);
`endif
    idle(4);

    // Bubbles: 1,0,0,1.
    cycle(0, 1, 0, 1, 0);
    cycle(0, 0, 1, 1, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 1, 1, 1, 0);
    idle(3);

    // Flush with two elements in flight.
    cycle(0, 1, 0, 1, 0);
    cycle(0, 1, 1, 1, 0);
    cycle(0, 1, 1, 1, 1);
    chk("fl_busy", 32'(busy_o), 32'd0);
    chk("fl_valid", 32'(valid_o), 32'd0);
    cycle(0, 1, 1, 1, 0);
    idle(3);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 199) == 0,
            $urandom_range(0, 9) < 7,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 9) < 6,
            $urandom_range(0, 49) == 0);
    end
    idle(4);

    // Row counter wrap: 65536 single-element rows from zero.
    cycle(1, 0, 0, 1, 0);
    for (int i = 0; i < 65536; i++) cycle(0, 1, 1, 1, 0);
    idle(N + 1);
    chk("wrap_row", 32'(row_cnt_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
